sisc_fetch: RTL

- Instruction-fetch and branch-resolution stage that sits directly upstream of the SISC control FSM.
- Owns the PC and IR and drives the instruction-memory read handshake.
- Decodes IR fields (opcode, mm, rd, rs, rt, imm) that feed the control FSM, register file and ALU.
- Resolves BRA/BRR/BNE/BNR against the 4-bit status word when the control FSM pulses br_eval during its execute state.

---
 rtl/sisc_pkg.sv | 37 +++
 rtl/sisc_br_unit.sv | 53 +++++
 rtl/sisc_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, status bit indices, IR field positions
// and the fetch-stage state encoding.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  // stat = {C,N,V,Z}
  localparam int ST_C = 3;
  localparam int ST_N = 2;
  localparam int ST_V = 1;
  localparam int ST_Z = 0;

  localparam int OPC_LSB = 28;
  localparam int MM_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int IMM_LSB = 0;

  localparam logic [31:0] HLT_WORD = 32'hF000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sisc_br_unit.sv
// Combinational branch resolver: decides taken and computes the target
// from the IR fields, the already-incremented pc and the status word.
module sisc_br_unit
  import sisc_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [3:0]    opcode,
  input  logic [3:0]    mm,
  input  logic [15:0]   imm,
  input  logic [AW-1:0] pc,
  input  logic [3:0]    stat,
  output logic          taken,
  output logic [AW-1:0] target
);

  logic          any_set;
  logic [AW-1:0] abs_tgt;
  logic [AW-1:0] rel_tgt;

  assign any_set = |(mm & stat);

  // Immediate widened or trimmed to the PC width; relative sum wraps in AW bits.
  if (AW > 16) begin : g_wide
    assign abs_tgt = {{(AW-16){1'b0}}, imm};
    assign rel_tgt = pc + {{(AW-16){imm[15]}}, imm};
  end else if (AW == 16) begin : g_eq
    assign abs_tgt = imm;
    assign rel_tgt = pc + imm;
  end else begin : g_narrow
    assign abs_tgt = imm[AW-1:0];
    assign rel_tgt = pc + imm[AW-1:0];
  end

  always_comb begin
    taken  = 1'b0;
    target = abs_tgt;
    case (opcode)
      BRA:     taken = (mm == 4'd0) || any_set;
      BRR: begin
        taken  = (mm == 4'd0) || any_set;
        target = rel_tgt;
      end
      BNE:     taken = !any_set;
      BNR: begin
        taken  = !any_set;
        target = rel_tgt;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch and branch resolution stage: owns PC/IR, drives the
// imem read handshake. Optional ack timeout under SISC_FETCH_TIMEOUT_EN.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int AW  = 16,
  parameter int IW  = 32,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_req,
  input  logic          br_eval,
  input  logic [3:0]    stat,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          imem_ack,
  output logic          ir_valid,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    rd,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          br_taken,
  output logic          fetch_err
);

  fetch_state_t  state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [IW-1:0] ir_reg, ir_next;
  logic          ir_valid_reg, ir_valid_next;
  logic          pending_reg, pending_next;
  logic          br_taken_reg, br_taken_next;
  logic          halted;
  logic          br_hit;
  logic [AW-1:0] br_target;

`ifdef SISC_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
`endif

  assign opcode    = ir_reg[OPC_LSB +: 4];
  assign mm        = ir_reg[MM_LSB +: 4];
  assign rd        = ir_reg[RD_LSB +: 4];
  assign rs        = ir_reg[RS_LSB +: 4];
  assign rt        = ir_reg[RT_LSB +: 4];
  assign imm       = ir_reg[IMM_LSB +: 16];
  assign pc        = pc_reg;
  assign imem_addr = pc_reg;
  assign imem_rd   = (state_reg == ST_REQ);
  assign busy      = (state_reg == ST_REQ);
  assign ir_valid  = ir_valid_reg;
  assign br_taken  = br_taken_reg;
  assign halted    = (opcode == HLT);

  sisc_br_unit #(.AW(AW)) u_br (
    .opcode (opcode),
    .mm     (mm),
    .imm    (imm),
    .pc     (pc_reg),
    .stat   (stat),
    .taken  (br_hit),
    .target (br_target)
  );

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_valid_next = ir_valid_reg;
    pending_next  = pending_reg;
    br_taken_next = 1'b0;
`ifdef SISC_FETCH_TIMEOUT_EN
    cnt_next      = cnt_reg;
    err_next      = err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (br_eval && br_hit) begin
          // Branch wins the cycle; a coincident fetch restarts from the new pc.
          pc_next       = br_target;
          br_taken_next = 1'b1;
          pending_next  = pending_reg | (fetch_req && !halted);
        end else if (!halted && (fetch_req || pending_reg)) begin
          state_next    = ST_REQ;
          ir_valid_next = 1'b0;
          pending_next  = 1'b0;
`ifdef SISC_FETCH_TIMEOUT_EN
          cnt_next      = '0;
`endif
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          ir_next       = imem_data;
          pc_next       = pc_reg + AW'(1);
          ir_valid_next = 1'b1;
          state_next    = ST_LOAD;
`ifdef SISC_FETCH_TIMEOUT_EN
        end else if (cnt_reg == CW'(TMO - 1)) begin
          ir_next       = IW'(HLT_WORD);
          ir_valid_next = 1'b1;
          err_next      = 1'b1;
          state_next    = ST_LOAD;
        end else begin
          cnt_next      = cnt_reg + CW'(1);
`endif
        end
      end
      ST_LOAD: begin
        state_next = ST_IDLE;
        if (br_eval && br_hit) begin
          pc_next       = br_target;
          br_taken_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= '0;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
      pending_reg  <= 1'b0;
      br_taken_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_valid_reg <= ir_valid_next;
      pending_reg  <= pending_next;
      br_taken_reg <= br_taken_next;
    end
  end

`ifdef SISC_FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end
  assign fetch_err = err_reg;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
